// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants shared with the timing generator, plus receiver FSM states.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE   = 640;
  localparam int unsigned H_TOTAL    = 800;
  localparam int unsigned H_SYNC_END = 752;
  localparam int unsigned V_ACTIVE   = 480;
  localparam int unsigned V_TOTAL    = 525;
  localparam int unsigned V_SYNC_END = 492;

  typedef enum logic [1:0] {
    SEARCH    = 2'd0,
    H_ALIGNED = 2'd1,
    LOCKED    = 2'd2
  } rx_state_t;

  function automatic logic [9:0] wrap_inc(input logic [9:0] val, input logic [9:0] last);
    return (val == last) ? '0 : val + 10'd1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Stage-0 sync register with prior-sample copy; flags a low-to-high transition.
module sync_edge_det (
  input  logic CLK_25MH,
  input  logic RST,
  input  logic sync_in,
  output logic rise
);

  logic sync_q;
  logic sync_prev;

  // Both clear high so a sync that is already high after reset is not an edge.
  always_ff @(posedge CLK_25MH) begin
    if (RST) begin
      sync_q    <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync_q    <= sync_in;
      sync_prev <= sync_q;
    end
  end

  assign rise = sync_q & ~sync_prev;

endmodule

// File: rtl/vga_rx.sv
// VGA receive side: recovers pixel coordinates from sync edges, tracks lock, flags timing errors.
module vga_rx #(
  parameter int unsigned H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_TOTAL    = vga_timing_pkg::H_TOTAL,
  parameter int unsigned H_SYNC_END = vga_timing_pkg::H_SYNC_END,
  parameter int unsigned V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_TOTAL    = vga_timing_pkg::V_TOTAL,
  parameter int unsigned V_SYNC_END = vga_timing_pkg::V_SYNC_END
) (
  input  logic       CLK_25MH,
  input  logic       RST,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [2:0] rgb_in,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [2:0] pix_rgb,
  output logic       frame_start,
  output logic [7:0] frame_count,
  output logic       locked,
  output logic       line_err,
  output logic       frame_err
);
  import vga_timing_pkg::*;

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC = 10'(H_SYNC_END);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SYNC = 10'(V_SYNC_END);

  logic       h_rise, v_rise;
  logic [2:0] rgb_s0;

  sync_edge_det u_hsync_det (.CLK_25MH(CLK_25MH), .RST(RST), .sync_in(hsync_in), .rise(h_rise));
  sync_edge_det u_vsync_det (.CLK_25MH(CLK_25MH), .RST(RST), .sync_in(vsync_in), .rise(v_rise));

  rx_state_t  state, state_nx;
  logic [9:0] h_pred, v_pred, hpos_nx, vpos_nx;
  logic       line_err_nx, frame_err_nx, frame_start_nx;

  // Decisions use the predicted position of the stage-0 sample; a line error wins over any v-rise.
  always_comb begin
    h_pred         = wrap_inc(pix_x, H_LAST);
    v_pred         = (pix_x == H_LAST) ? wrap_inc(pix_y, V_LAST) : pix_y;
    hpos_nx        = h_pred;
    vpos_nx        = v_pred;
    state_nx       = state;
    line_err_nx    = 1'b0;
    frame_err_nx   = 1'b0;
    unique case (state)
      SEARCH: begin
        if (h_rise) begin
          hpos_nx  = H_SYNC;
          state_nx = H_ALIGNED;
        end
      end
      H_ALIGNED: begin
        if (h_rise && (h_pred != H_SYNC)) begin
          line_err_nx = 1'b1;
          hpos_nx     = H_SYNC;
        end else if (v_rise) begin
          if (h_pred == '0) begin
            vpos_nx  = V_SYNC;
            state_nx = LOCKED;
          end else begin
            frame_err_nx = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (h_rise && (h_pred != H_SYNC)) begin
          line_err_nx = 1'b1;
          hpos_nx     = H_SYNC;
          state_nx    = H_ALIGNED;
        end else if (v_rise && ((v_pred != V_SYNC) || (h_pred != '0))) begin
          frame_err_nx = 1'b1;
          state_nx     = H_ALIGNED;
        end
      end
      default: state_nx = SEARCH;
    endcase
    frame_start_nx = (state_nx == LOCKED) && (hpos_nx == '0) && (vpos_nx == '0);
  end

  always_ff @(posedge CLK_25MH) begin
    if (RST) begin
      state       <= SEARCH;
      rgb_s0      <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_nx;
      rgb_s0      <= rgb_in;
      pix_x       <= hpos_nx;
      pix_y       <= vpos_nx;
      pix_rgb     <= rgb_s0;
      pix_valid   <= (state_nx == LOCKED) && (hpos_nx < H_ACT) && (vpos_nx < V_ACT);
      frame_start <= frame_start_nx;
      line_err    <= line_err_nx;
      frame_err   <= frame_err_nx;
      if (frame_start_nx) frame_count <= frame_count + 8'd1;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_rx.sv
// Scoreboard bench for vga_rx on a scaled-down raster; a sample-level reference model predicts every output.
module tb_vga_rx;

  localparam int HA  = 16;
  localparam int HT  = 24;
  localparam int HSE = 22;
  localparam int VA  = 3;
  localparam int VT  = 6;
  localparam int VSE = 5;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic [2:0] rgb_in = '0;
  logic       pix_valid, frame_start, locked, line_err, frame_err;
  logic [9:0] pix_x, pix_y;
  logic [2:0] pix_rgb;
  logic [7:0] frame_count;

  vga_rx #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_END(HSE),
    .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_END(VSE)
  ) dut (
    .CLK_25MH(clk), .RST(RST), .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .frame_count(frame_count), .locked(locked),
    .line_err(line_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned tag;
    logic        valid, fs, lk, le, fe;
    logic [2:0]  rgb;
    logic [7:0]  fc;
    int          x, y;
    bit          chkx, chky;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int wraps = 0;

  // Reference receiver: position known once aligned, line index trusted only when locked.
  bit m_ph = 1, m_pv = 1, m_aligned = 0, m_locked = 0;
  int m_hx = 0, m_vy = 0, m_fc = 0;

  task automatic model_sample(input logic h, input logic v, input logic [2:0] c, input int unsigned tag);
    exp_t e;
    bit hr, vr, le, fe, fs;
    int hp, vp;
    hr = h && !m_ph;
    vr = v && !m_pv;
    m_ph = h;
    m_pv = v;
    le = 0;
    fe = 0;
    if (!m_aligned) begin
      if (hr) begin
        m_aligned = 1;
        m_hx = HSE;
      end
    end else begin
      hp = (m_hx + 1) % HT;
      vp = (m_hx == HT - 1) ? (m_vy + 1) % VT : m_vy;
      m_hx = hp;
      m_vy = vp;
      if (hr && hp != HSE) begin
        le = 1;
        m_hx = HSE;
        m_locked = 0;
      end else if (vr) begin
        if (!m_locked) begin
          if (hp == 0) begin
            m_vy = VSE;
            m_locked = 1;
          end else fe = 1;
        end else if (vp != VSE || hp != 0) begin
          fe = 1;
          m_locked = 0;
        end
      end
    end
    fs = m_locked && m_hx == 0 && m_vy == 0;
    if (fs) m_fc = (m_fc + 1) % 256;
    e.tag = tag;
    e.valid = m_locked && m_hx < HA && m_vy < VA;
    e.fs = fs;
    e.lk = m_locked;
    e.le = le;
    e.fe = fe;
    e.rgb = c;
    e.fc = 8'(m_fc);
    e.x = m_hx;
    e.y = m_vy;
    e.chkx = m_aligned;
    e.chky = m_locked;
    sb.push_back(e);
  endtask

  // Called just after a rising edge; inputs are captured on the next edge, outputs appear one edge later.
  task automatic step(input logic r, input logic h, input logic v, input logic [2:0] c);
    exp_t e;
    RST = r;
    hsync_in = h;
    vsync_in = v;
    rgb_in = c;
    if (r) begin
      if (sb.size() > 0 && sb[$].tag == cyc + 1) void'(sb.pop_back());
      e.tag = cyc + 1;
      e.valid = 0; e.fs = 0; e.lk = 0; e.le = 0; e.fe = 0;
      e.rgb = '0; e.fc = '0; e.x = 0; e.y = 0; e.chkx = 1; e.chky = 1;
      sb.push_back(e);
      m_ph = 1; m_pv = 1; m_aligned = 0; m_locked = 0; m_fc = 0;
      model_sample(1'b1, 1'b1, 3'b000, cyc + 2);
    end else begin
      model_sample(h, v, c, cyc + 2);
    end
    @(posedge clk);
    #1;
  endtask

  int gx = 0, gy = 0;
  bit bars = 0, stretch = 0, vshift = 0;

  task automatic gen_cycle(input logic r);
    logic h, v;
    logic [2:0] c;
    h = !(gx >= HSE - 2 && gx < HSE);
    v = !(gy == VSE - 1 || (vshift && gy == VSE && gx < 5));
    if (bars && gx < HA && gy < VA) c = 3'(gx / (HA / 8));
    else c = 3'($urandom);
    step(r, h, v, c);
    if (stretch && gx == HT - 1) stretch = 0;
    else begin
      gx++;
      if (gx == HT) begin
        gx = 0;
        gy++;
        if (gy == VT) begin
          gy = 0;
          vshift = 0;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) gen_cycle(1'b0);
  endtask

  task automatic run_until(input int tx, input int ty);
    for (int i = 0; i < 2 * FRAME && !(gx == tx && gy == ty); i++) gen_cycle(1'b0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, req);
    end
  endtask

  exp_t me;
  logic [7:0] prev_fc = '0;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      me = sb.pop_front();
      vectors++;
      chk("tag", cyc, me.tag);
      chk("pix_valid", pix_valid, me.valid);
      chk("frame_start", frame_start, me.fs);
      chk("locked", locked, me.lk);
      chk("line_err", line_err, me.le);
      chk("frame_err", frame_err, me.fe);
      chk("pix_rgb", pix_rgb, me.rgb);
      chk("frame_count", frame_count, me.fc);
      if (me.chkx) chk("pix_x", pix_x, me.x);
      if (me.chky) chk("pix_y", pix_y, me.y);
    end
    if (prev_fc == 8'd255 && frame_count == 8'd0) wraps++;
    prev_fc = frame_count;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    gx = $urandom_range(HT - 1);
    gy = $urandom_range(VT - 1);
    gen_cycle(1'b1);
    gen_cycle(1'b1);
    run(4 * FRAME);
    bars = 1;
    run(2 * FRAME);
    bars = 0;
    run_until($urandom_range(HT - 1), $urandom_range(VT - 1));
    stretch = 1;
    run(3 * FRAME);
    run_until(0, 0);
    vshift = 1;
    run(3 * FRAME);
    run_until($urandom_range(HA - 1, 1), $urandom_range(VA - 1));
    gen_cycle(1'b1);
    run(3 * FRAME);
    run(258 * FRAME);
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    vectors++;
    if (wraps == 0) begin
      miscompares++;
      $display("FAIL fc_wrap: got %0d wraps expected at least 1", wraps);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_rx.md
Name: vga_rx

Overview:
- Receive side of the 640x480@60 VGA link: consumes hsync/vsync/3-bit RGB as driven by the team's 800x525 timing generator.
- Recovers pixel coordinates and tracks lock; flags line and frame timing errors.
- Used for loopback self-test of the video path and for capturing/compositing an external VGA stream into the game overlay.
- All inputs are synchronous to CLK_25MH.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_TOTAL, 800, clocks per line
H_SYNC_END, 752, horizontal position of the first sample with hsync high after the pulse
V_ACTIVE, 480, visible lines per frame
V_TOTAL, 525, lines per frame
V_SYNC_END, 492, line index of the first sample with vsync high after the pulse (arrives at hpos 0)

Ports:
CLK_25MH  in   1   pixel clock, 25 MHz
RST       in   1   synchronous reset, active-high
hsync_in  in   1   horizontal sync, active-low
vsync_in  in   1   vertical sync, active-low
rgb_in    in   3   pixel colour, {R,G,B}
pix_valid out  1   registered; high on in-frame active pixels while locked
pix_x     out  10  recovered column, 0..H_TOTAL-1
pix_y     out  10  recovered line, 0..V_TOTAL-1
pix_rgb   out  3   rgb_in delayed to align with pix_x/pix_y
frame_start out 1  one-cycle pulse with pix (0,0) while locked
frame_count out 8  frames seen while locked; wraps 255->0
locked    out  1   high in LOCKED state
line_err  out  1   one-cycle pulse on hsync misalignment
frame_err out  1   one-cycle pulse on vsync misalignment

Behaviour:
- Stage 0: hsync_in, vsync_in and rgb_in are registered together. Prior-sample copies of both syncs are kept for edge detection.
- Stage 1: decode and output registers. Input-to-output latency is exactly 2 clocks for every output.
- Rising edges are detected on stage-0 samples:
  - h-rise: sample is 1 and previous sample was 0.
  - v-rise: same rule on vsync.
- Free-running counters hpos and vpos:
  - hpos increments; wraps H_TOTAL-1 -> 0.
  - vpos increments when hpos wraps; wraps V_TOTAL-1 -> 0.
- FSM states:
  - SEARCH (reset state):
    - counters are don't-care; no error pulses.
    - on h-rise: hpos := H_SYNC_END for that sample; go H_ALIGNED.
  - H_ALIGNED:
    - h-rise with predicted hpos != H_SYNC_END -> line_err, hpos realigned, stay.
    - v-rise with hpos == 0 -> vpos := V_SYNC_END; go LOCKED.
    - v-rise with hpos != 0 -> frame_err; stay.
  - LOCKED:
    - h-rise with predicted hpos != H_SYNC_END -> line_err, hpos realigned; go H_ALIGNED.
    - v-rise with (vpos != V_SYNC_END or hpos != 0) -> frame_err, vpos unchanged; go H_ALIGNED.
- Simultaneous h-rise error and v-rise in the same cycle: line_err takes priority and the v-rise is ignored. The next state is H_ALIGNED.
- Outputs:
  - pix_valid = LOCKED and hpos < H_ACTIVE and vpos < V_ACTIVE.
  - pix_x/pix_y = hpos/vpos in every state; they are meaningful only when locked.
  - frame_start = LOCKED and hpos == 0 and vpos == 0. frame_count increments on it.
- Sync pulse widths and blanking RGB are not checked. Only rising-edge positions count.
- Reset, including mid-frame: on the clock edge where RST is sampled high, all outputs go to 0 (pix_* = 0, locked = 0, frame_count = 0) and state goes to SEARCH. Input registers clear to hsync/vsync = 1, rgb = 0, so a high sync after reset is not an edge.
- Arithmetic: all counters are 10-bit unsigned; comparisons against parameters are unsigned.

Decomposition:
- Package vga_timing_pkg holds:
  - H_/V_ timing constants, shared with the timing generator;
  - FSM state encoding (SEARCH=2'd0, H_ALIGNED=2'd1, LOCKED=2'd2).
- One sub-module, sync_edge_det: stage-0 register plus rising-edge detect, instantiated once for hsync and once for vsync.

Test Plan:
1. Reset, then drive a bench 800x525 generator from mid-frame:
   - locked rises on the 2nd clock after the first vsync rising edge.
   - first frame_start arrives 33 lines later with pix_x=0, pix_y=0.
2. Two clean frames while locked: pix_valid count per frame = 307200; line_err and frame_err never assert; frame_count advances by 2.
3. Colour bars (80-pixel bands 000..111): pix_rgb at pix_x=80 equals 3'b001, at pix_x=639 equals 3'b111; alignment to pix_x holds exactly at 2-clock latency.
4. Stretch one line to 801 clocks while locked:
   - line_err pulses once; locked drops.
   - locked is regained after the next clean vsync rising edge; pix_x realigned to 752 at the edge.
5. Shift the vsync rising edge to hpos 5:
   - frame_err pulses; locked=0 until a correct vsync rising edge.
   - frame_count is unchanged over that frame.
6. Assert RST for 1 clock mid-line at pix (300,200):
   - all outputs are 0 on the next clock; state is SEARCH.
   - relock follows scenario 1 timing.
   - frame_count wraps 255->0 after 256 locked frames.
